ysyx_store_queue: RTL and testbench

Committed-store buffer between the commit stage and the data memory port. Accepts retired stores over the `cm_store_if` commit channel, holds them in a FIFO, and drains them in program order to memory through a request/response write handshake. It also tells the load path whether a load overlaps a pending store, with optional data forwarding. Committed stores are architectural, so the queue is never flushed; only reset discards entries.

---
 rtl/ysyx_sq_pkg.sv | 30 +++
 rtl/cm_store_if.sv | 14 +
 rtl/ysyx_sq_fwd.sv | 50 +++++
 rtl/ysyx_store_queue.sv | 148 ++++++++++++++
 tb/tb_ysyx_store_queue.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_sq_pkg.sv
// Shared types, size codes and strobe helper for the committed-store queue.
// Forwarding is optional via YSYX_SQ_FORWARD_EN; both builds use these definitions.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
package ysyx_sq_pkg;
  localparam int SQ_XLEN = `YSYX_XLEN;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, RESP} sq_state_t;

  typedef struct packed {
    logic [SQ_XLEN-1:0] waddr;
    logic [SQ_XLEN-1:0] wdata;
    logic [3:0]         wstrb;
  } sq_entry_t;

  function automatic logic [3:0] sq_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      SZ_BYTE: base = 4'b0001;
      SZ_HALF: base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction
endpackage

// File: rtl/cm_store_if.sv
// Commit-stage store channel: one retired store per cycle when valid && store.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
interface cm_store_if #(parameter int XLEN = `YSYX_XLEN);
  logic            valid;
  logic            store;
  logic [4:0]      alu;
  logic [XLEN-1:0] sq_waddr;
  logic [XLEN-1:0] sq_wdata;

  modport in  (input  valid, store, alu, sq_waddr, sq_wdata);
  modport out (output valid, store, alu, sq_waddr, sq_wdata);
endinterface

// File: rtl/ysyx_sq_fwd.sv
// Combinational youngest-match search over queued stores; forwards on full cover,
// otherwise flags a conflict. Only built when YSYX_SQ_FORWARD_EN is defined.
module ysyx_sq_fwd import ysyx_sq_pkg::*; #(
  parameter int SQ_SIZE = 4,
  parameter int PW      = $clog2(SQ_SIZE)
) (
  input  sq_entry_t          i_entries [SQ_SIZE],
  input  logic [SQ_SIZE-1:0] i_valid,
  input  logic [PW-1:0]      i_tail,
  input  logic               i_ld_valid,
  input  logic [SQ_XLEN-1:0] i_ld_waddr,
  input  logic [3:0]         i_ld_strb,
  output logic               o_conflict,
  output logic               o_fwd_hit,
  output logic [SQ_XLEN-1:0] o_fwd_data
);
  logic               w_found;
  logic [PW-1:0]      w_idx;
  logic [PW-1:0]      w_sel;
  logic [3:0]         w_sel_strb;
  logic               w_cover;
  logic [SQ_XLEN-1:0] w_mask;

  // Walk backwards from the tail so the first hit is the youngest store.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 1; k <= SQ_SIZE; k++) begin
      w_idx = i_tail - PW'(k);
      if (!w_found && i_valid[w_idx] && (i_entries[w_idx].waddr == i_ld_waddr) &&
          |(i_entries[w_idx].wstrb & i_ld_strb)) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_sel_strb = i_entries[w_sel].wstrb;
  assign w_cover    = (w_sel_strb & i_ld_strb) == i_ld_strb;

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < 4; b++) w_mask[8*b +: 8] = {8{w_sel_strb[b]}};
  end

  assign o_fwd_hit  = i_ld_valid && w_found && w_cover;
  assign o_conflict = i_ld_valid && w_found && !w_cover;
  assign o_fwd_data = o_fwd_hit ? (i_entries[w_sel].wdata & w_mask) : '0;
endmodule

// File: rtl/ysyx_store_queue.sv
// Committed-store FIFO draining in order to memory; enqueue-to-mem_wvalid 2 cycles, refuses stores when full.
// Load lookup flags overlap with pending stores; YSYX_SQ_FORWARD_EN adds youngest-match forwarding.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
module ysyx_store_queue import ysyx_sq_pkg::*; #(
  parameter int SQ_SIZE = 4,
  parameter int XLEN    = `YSYX_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  cm_store_if.in          cm,
  output logic            sq_ready,
  output logic            sq_empty,
  output logic            mem_wvalid,
  input  logic            mem_wready,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_bvalid,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [4:0]      ld_alu,
  output logic            ld_conflict,
  output logic            ld_fwd_hit,
  output logic [XLEN-1:0] ld_fwd_data
);
  localparam int PW = $clog2(SQ_SIZE);
  localparam logic [PW:0]   FULL  = (PW+1)'(SQ_SIZE);
  localparam logic [PW:0]   ONE_C = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_P = PW'(1);

  sq_entry_t     r_entries [SQ_SIZE];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  sq_state_t     r_state;
  logic          r_wvalid;
  sq_entry_t     r_req;

  logic               w_enq;
  logic               w_deq;
  sq_entry_t          w_new;
  logic [SQ_SIZE-1:0] w_valid;
  logic [XLEN-1:0]    w_ld_waddr;
  logic [3:0]         w_ld_strb;
  logic               w_unused;

  assign sq_ready = (r_count != FULL);
  assign sq_empty = (r_count == '0) && (r_state == IDLE);
  assign w_enq    = cm.valid && cm.store && sq_ready;
  assign w_deq    = (r_state == RESP) && mem_bvalid;
  assign w_unused = ^{cm.alu[4:2], ld_alu[4:2]};

  assign w_new.waddr = {cm.sq_waddr[XLEN-1:2], 2'b00};
  assign w_new.wdata = cm.sq_wdata << {cm.sq_waddr[1:0], 3'b000};
  assign w_new.wstrb = sq_strb(cm.alu[1:0], cm.sq_waddr[1:0]);

  always_ff @(posedge clock) begin
    if (w_enq) r_entries[r_tail] <= w_new;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + ONE_P;
      if (w_deq) r_head <= r_head + ONE_P;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head stays counted until its response; RESP hands the next entry straight to REQ.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_wvalid <= 1'b0;
      r_req    <= '0;
    end else begin
      case (r_state)
        IDLE: if (r_count != '0) begin
          r_state  <= REQ;
          r_wvalid <= 1'b1;
          r_req    <= r_entries[r_head];
        end
        REQ: if (mem_wready) begin
          r_state  <= RESP;
          r_wvalid <= 1'b0;
        end
        RESP: if (mem_bvalid) begin
          if (r_count > ONE_C) begin
            r_state  <= REQ;
            r_wvalid <= 1'b1;
            r_req    <= r_entries[r_head + ONE_P];
          end else begin
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_wvalid = r_wvalid;
  assign mem_waddr  = r_req.waddr;
  assign mem_wdata  = r_req.wdata;
  assign mem_wstrb  = r_req.wstrb;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < SQ_SIZE; i++) w_valid[i] = {1'b0, PW'(i) - r_head} < r_count;
  end

  assign w_ld_waddr = {ld_addr[XLEN-1:2], 2'b00};
  assign w_ld_strb  = sq_strb(ld_alu[1:0], ld_addr[1:0]);

`ifdef YSYX_SQ_FORWARD_EN
  ysyx_sq_fwd #(.SQ_SIZE(SQ_SIZE)) u_fwd (
    .i_entries  (r_entries),
    .i_valid    (w_valid),
    .i_tail     (r_tail),
    .i_ld_valid (ld_valid),
    .i_ld_waddr (w_ld_waddr),
    .i_ld_strb  (w_ld_strb),
    .o_conflict (ld_conflict),
    .o_fwd_hit  (ld_fwd_hit),
    .o_fwd_data (ld_fwd_data)
  );
`else
  logic w_match;
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < SQ_SIZE; i++) begin
      if (w_valid[i] && (r_entries[i].waddr == w_ld_waddr) && |(r_entries[i].wstrb & w_ld_strb))
        w_match = 1'b1;
    end
  end
  assign ld_conflict = ld_valid && w_match;
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;
`endif
endmodule

// File: tb/tb_ysyx_store_queue.sv
// Directed bench for ysyx_store_queue: drain timing, strobes, full/backpressure, lookup and reset.
module tb_ysyx_store_queue;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sq_ready, sq_empty, mem_wvalid, mem_wready, mem_bvalid;
  logic [31:0] mem_waddr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        ld_valid, ld_conflict, ld_fwd_hit;
  logic [31:0] ld_addr, ld_fwd_data;
  logic [4:0]  ld_alu;

  int n_assert = 0;
  int n_fail   = 0;

  cm_store_if #(.XLEN(32)) cm_if ();

  always #5 clock = ~clock;

  ysyx_store_queue #(.SQ_SIZE(4), .XLEN(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .cm          (cm_if),
    .sq_ready    (sq_ready),
    .sq_empty    (sq_empty),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_bvalid  (mem_bvalid),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_alu      (ld_alu),
    .ld_conflict (ld_conflict),
    .ld_fwd_hit  (ld_fwd_hit),
    .ld_fwd_data (ld_fwd_data)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] alu);
    cm_if.valid = 1'b1; cm_if.store = 1'b1; cm_if.alu = alu;
    cm_if.sq_waddr = addr; cm_if.sq_wdata = data;
    tick();
    cm_if.valid = 1'b0; cm_if.store = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] addr, input logic [4:0] alu);
    ld_valid = 1'b1; ld_addr = addr; ld_alu = alu;
    #1;
  endtask

  task automatic drain_one(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_data);
    int n = 0;
    while (!mem_wvalid && n < 20) begin
      tick();
      n++;
    end
    chk1({tag, "_wvalid"}, mem_wvalid, 1'b1);
    chk32({tag, "_waddr"}, mem_waddr, exp_addr);
    chk32({tag, "_wdata"}, mem_wdata, exp_data);
    mem_wready = 1'b1; tick(); mem_wready = 1'b0;
    mem_bvalid = 1'b1; tick(); mem_bvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cm_if.valid = 1'b0; cm_if.store = 1'b0; cm_if.alu = '0;
    cm_if.sq_waddr = '0; cm_if.sq_wdata = '0;
    mem_wready = 1'b0; mem_bvalid = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_alu = '0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk1("rst_ready", sq_ready, 1'b1);
    chk1("rst_empty", sq_empty, 1'b1);
    chk1("rst_wvalid", mem_wvalid, 1'b0);
    chk32("rst_waddr", mem_waddr, 32'h0);
    chk32("rst_wdata", mem_wdata, 32'h0);
    chk32("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk1("rst_conflict", ld_conflict, 1'b0);
    chk1("rst_fwd_hit", ld_fwd_hit, 1'b0);
    chk32("rst_fwd_data", ld_fwd_data, 32'h0);

    // Single sw; lookup in the enqueue cycle must not see it
    cm_if.valid = 1'b1; cm_if.store = 1'b1; cm_if.alu = 5'b00010;
    cm_if.sq_waddr = 32'h8000_0004; cm_if.sq_wdata = 32'hDEAD_BEEF;
    lookup(32'h8000_0004, 5'b00010);
    chk1("samecyc_conflict", ld_conflict, 1'b0);
    chk1("samecyc_fwd_hit", ld_fwd_hit, 1'b0);
    tick();
    cm_if.valid = 1'b0; cm_if.store = 1'b0; ld_valid = 1'b0;
    chk1("sw_lat1_wvalid", mem_wvalid, 1'b0);
    chk1("sw_lat1_empty", sq_empty, 1'b0);
    tick();
    chk1("sw_lat2_wvalid", mem_wvalid, 1'b1);
    chk32("sw_waddr", mem_waddr, 32'h8000_0004);
    chk32("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk32("sw_wstrb", {28'h0, mem_wstrb}, 32'hF);
    lookup(32'h8000_0004, 5'b00010);
`ifdef YSYX_SQ_FORWARD_EN
    chk1("sw_lw_conflict", ld_conflict, 1'b0);
    chk1("sw_lw_fwd_hit", ld_fwd_hit, 1'b1);
    chk32("sw_lw_fwd_data", ld_fwd_data, 32'hDEAD_BEEF);
`else
    chk1("sw_lw_conflict", ld_conflict, 1'b1);
    chk1("sw_lw_fwd_hit", ld_fwd_hit, 1'b0);
`endif
    ld_valid = 1'b0;
    mem_wready = 1'b1; tick(); mem_wready = 1'b0;
    chk1("sw_resp_wvalid", mem_wvalid, 1'b0);
    chk1("sw_resp_empty", sq_empty, 1'b0);
    mem_bvalid = 1'b1; tick(); mem_bvalid = 1'b0;
    chk1("sw_done_empty", sq_empty, 1'b1);

    // sb at byte 3, then request held 5 cycles without wready
    enq(32'h8000_0003, 32'h0000_00AB, 5'b00000);
    tick();
    chk1("sb_wvalid", mem_wvalid, 1'b1);
    chk32("sb_waddr", mem_waddr, 32'h8000_0000);
    chk32("sb_wdata", mem_wdata, 32'hAB00_0000);
    chk32("sb_wstrb", {28'h0, mem_wstrb}, 32'h8);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk1("hold_wvalid", mem_wvalid, 1'b1);
      chk32("hold_waddr", mem_waddr, 32'h8000_0000);
      chk32("hold_wdata", mem_wdata, 32'hAB00_0000);
      chk32("hold_wstrb", {28'h0, mem_wstrb}, 32'h8);
    end
    mem_wready = 1'b1; tick(); mem_wready = 1'b0;
    chk1("sb_resp_wvalid", mem_wvalid, 1'b0);
    mem_bvalid = 1'b1; tick(); mem_bvalid = 1'b0;
    chk1("sb_done_empty", sq_empty, 1'b1);

    // Five stores into a four-entry queue with memory stalled
    for (int i = 1; i <= 4; i++) begin
      cm_if.valid = 1'b1; cm_if.store = 1'b1; cm_if.alu = 5'b00010;
      cm_if.sq_waddr = 32'h200 + 32'(4*i); cm_if.sq_wdata = 32'h1000 + 32'(i);
      tick();
    end
    chk1("full_ready", sq_ready, 1'b0);
    cm_if.sq_waddr = 32'h214; cm_if.sq_wdata = 32'h1005;
    tick();
    chk1("full_held_ready", sq_ready, 1'b0);
    chk1("full_head_wvalid", mem_wvalid, 1'b1);
    chk32("full_head_waddr", mem_waddr, 32'h204);
    mem_wready = 1'b1; tick(); mem_wready = 1'b0;
    chk1("full_resp_ready", sq_ready, 1'b0);
    mem_bvalid = 1'b1; tick(); mem_bvalid = 1'b0;
    chk1("deq_ready", sq_ready, 1'b1);
    chk1("no_bubble_wvalid", mem_wvalid, 1'b1);
    chk32("no_bubble_waddr", mem_waddr, 32'h208);
    tick();
    cm_if.valid = 1'b0; cm_if.store = 1'b0;
    chk1("fifth_enq_ready", sq_ready, 1'b0);
    drain_one("drain2", 32'h208, 32'h1002);
    drain_one("drain3", 32'h20C, 32'h1003);
    drain_one("drain4", 32'h210, 32'h1004);
    drain_one("drain5", 32'h214, 32'h1005);
    chk1("drain_empty", sq_empty, 1'b1);

    // Overlap lookups: word store then a younger byte store in the same word
    enq(32'h100, 32'h1122_3344, 5'b00010);
    enq(32'h101, 32'h0000_0055, 5'b00000);
    lookup(32'h100, 5'b00010);
    chk1("lw100_conflict", ld_conflict, 1'b1);
    chk1("lw100_fwd_hit", ld_fwd_hit, 1'b0);
    lookup(32'h101, 5'b00000);
`ifdef YSYX_SQ_FORWARD_EN
    chk1("lb101_conflict", ld_conflict, 1'b0);
    chk1("lb101_fwd_hit", ld_fwd_hit, 1'b1);
    chk32("lb101_fwd_data", ld_fwd_data, 32'h0000_5500);
`else
    chk1("lb101_conflict", ld_conflict, 1'b1);
    chk1("lb101_fwd_hit", ld_fwd_hit, 1'b0);
    chk32("lb101_fwd_data", ld_fwd_data, 32'h0);
`endif
    lookup(32'h102, 5'b00000);
`ifdef YSYX_SQ_FORWARD_EN
    chk1("lb102_conflict", ld_conflict, 1'b0);
    chk1("lb102_fwd_hit", ld_fwd_hit, 1'b1);
    chk32("lb102_fwd_data", ld_fwd_data, 32'h1122_3344);
`else
    chk1("lb102_conflict", ld_conflict, 1'b1);
    chk1("lb102_fwd_hit", ld_fwd_hit, 1'b0);
`endif
    lookup(32'h104, 5'b00010);
    chk1("lw104_conflict", ld_conflict, 1'b0);
    chk1("lw104_fwd_hit", ld_fwd_hit, 1'b0);
    ld_valid = 1'b0;

    // Reset while the head is in RESP with three entries queued
    enq(32'h108, 32'h0000_0077, 5'b00010);
    chk32("pre_rst_waddr", mem_waddr, 32'h100);
    mem_wready = 1'b1; tick(); mem_wready = 1'b0;
    chk1("pre_rst_wvalid", mem_wvalid, 1'b0);
    chk1("pre_rst_empty", sq_empty, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk1("mid_rst_empty", sq_empty, 1'b1);
    chk1("mid_rst_wvalid", mem_wvalid, 1'b0);
    chk1("mid_rst_ready", sq_ready, 1'b1);
    lookup(32'h100, 5'b00010);
    chk1("mid_rst_conflict", ld_conflict, 1'b0);
    ld_valid = 1'b0;
    mem_bvalid = 1'b1; tick(); mem_bvalid = 1'b0;
    chk1("stray_b_empty", sq_empty, 1'b1);
    chk1("stray_b_wvalid", mem_wvalid, 1'b0);
    tick(); tick();
    chk1("stray_b_idle_wvalid", mem_wvalid, 1'b0);
    chk1("stray_b_idle_ready", sq_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
